// File: rtl/seq_detect_prog_pkg.sv
// rtl/seq_detect_prog_pkg.sv - shared types, limits and width helpers for the programmable sequence detector
package seq_detect_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_RUN   = 2'd2
  } ctrl_state_e;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width needed to hold a matched-prefix length 0..PAT_W.
  function automatic int idx_width(input int pat_w);
    return clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_dfa_builder.sv
// rtl/seq_dfa_builder.sv - builds the KMP next-state table one row per cycle after start
module seq_dfa_builder
  import seq_detect_prog_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int IDX_W = idx_width(PAT_W)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [PAT_W-1:0]            pattern,
  output logic [PAT_W-1:0][IDX_W-1:0] delta0,
  output logic [PAT_W-1:0][IDX_W-1:0] delta1,
  output logic [IDX_W-1:0]            border,
  output logic                        done
);

  logic                        busy_q;
  logic [IDX_W-1:0]            k_q;
  logic [IDX_W-1:0]            x_q;
  logic [IDX_W-1:0]            border_q;
  logic [PAT_W-1:0][IDX_W-1:0] d0_q;
  logic [PAT_W-1:0][IDX_W-1:0] d1_q;

  logic             pat_bit_k;
  logic [IDX_W-1:0] x_row0;
  logic [IDX_W-1:0] x_row1;
  logic [IDX_W-1:0] row0_d;
  logic [IDX_W-1:0] row1_d;
  logic             last_row;

  assign last_row = (k_q == IDX_W'(PAT_W));
  assign done     = busy_q && last_row;
  assign delta0   = d0_q;
  assign delta1   = d1_q;
  assign border   = border_q;

  // x_q tracks fail(k); its row is always already written because fail(k) < k.
  always_comb begin
    pat_bit_k = 1'b0;
    x_row0    = '0;
    x_row1    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (k_q == IDX_W'(i)) pat_bit_k = pattern[PAT_W-1-i];
      if (x_q == IDX_W'(i)) begin
        x_row0 = d0_q[i];
        x_row1 = d1_q[i];
      end
    end
    row0_d = !pat_bit_k ? k_q + 1'b1 : ((k_q == '0) ? '0 : x_row0);
    row1_d =  pat_bit_k ? k_q + 1'b1 : ((k_q == '0) ? '0 : x_row1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      k_q      <= '0;
      x_q      <= '0;
      border_q <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      k_q    <= '0;
      x_q    <= '0;
    end else if (busy_q) begin
      if (last_row) begin
        border_q <= x_q;
        busy_q   <= 1'b0;
      end else begin
        for (int i = 0; i < PAT_W; i++) begin
          if (k_q == IDX_W'(i)) begin
            d0_q[i] <= row0_d;
            d1_q[i] <= row1_d;
          end
        end
        if (k_q != '0) x_q <= pat_bit_k ? x_row1 : x_row0;
        k_q <= k_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector with overlap mode and saturating match counter
module seq_detect_prog
  import seq_detect_prog_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap,
  input  logic             din_valid,
  input  logic             din,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam int IDX_W = idx_width(PAT_W);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("PAT_W out of range");
  end

  ctrl_state_e      state_q;
  logic             armed_q;
  logic [PAT_W-1:0] pattern_q;
  logic             overlap_q;
  logic [IDX_W-1:0] progress_q;
  logic [IDX_W-1:0] progress_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic [PAT_W-1:0][IDX_W-1:0] delta0;
  logic [PAT_W-1:0][IDX_W-1:0] delta1;
  logic [IDX_W-1:0]            border;
  logic                        build_done;
  logic [IDX_W-1:0]            row0;
  logic [IDX_W-1:0]            row1;

  seq_dfa_builder #(
    .PAT_W (PAT_W),
    .IDX_W (IDX_W)
  ) u_builder (
    .clk     (clk),
    .reset   (reset),
    .start   (load),
    .pattern (pattern_q),
    .delta0  (delta0),
    .delta1  (delta1),
    .border  (border),
    .done    (build_done)
  );

  assign armed       = armed_q;
  assign match_count = count_q;
  assign match       = armed_q && din_valid && (progress_q == IDX_W'(PAT_W-1)) &&
                       (din == pattern_q[0]);

  always_comb begin
    row0 = '0;
    row1 = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (progress_q == IDX_W'(i)) begin
        row0 = delta0[i];
        row1 = delta1[i];
      end
    end

    progress_d = progress_q;
    if (load) begin
      progress_d = '0;
    end else if (armed_q && din_valid) begin
      if (match) progress_d = overlap_q ? border : '0;
      else       progress_d = din ? row1 : row0;
    end

    // A load in the same cycle as a match wins: the counter clears.
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      pattern_q <= '0;
      overlap_q <= 1'b0;
    end else if (load) begin
      state_q   <= ST_BUILD;
      armed_q   <= 1'b0;
      pattern_q <= pattern_in;
      overlap_q <= overlap;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          armed_q <= 1'b0;
        end
        ST_BUILD: begin
          if (build_done) begin
            state_q <= ST_RUN;
            armed_q <= 1'b1;
          end
        end
        ST_RUN: begin
          armed_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      progress_q <= '0;
      count_q    <= '0;
    end else begin
      progress_q <= progress_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - directed self-checking bench for seq_detect_prog at three pattern widths
module tb_seq_detect_prog;

  logic       clk;
  logic       reset;
  logic       overlap;
  logic       din_valid;
  logic       din;
  logic       load_a, load_b, load_c;
  logic [3:0] pattern_a;
  logic [2:0] pattern_b;
  logic [1:0] pattern_c;
  logic       armed_a, armed_b, armed_c;
  logic       match_a, match_b, match_c;
  logic [7:0] count_a, count_b;
  logic [1:0] count_c;

  int n_cmp = 0;
  int n_err = 0;

  seq_detect_prog #(.PAT_W(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .load(load_a), .pattern_in(pattern_a), .overlap(overlap),
    .din_valid(din_valid), .din(din), .armed(armed_a), .match(match_a), .match_count(count_a)
  );

  seq_detect_prog #(.PAT_W(3), .CNT_W(8)) u_dut_b (
    .clk(clk), .reset(reset), .load(load_b), .pattern_in(pattern_b), .overlap(overlap),
    .din_valid(din_valid), .din(din), .armed(armed_b), .match(match_b), .match_count(count_b)
  );

  seq_detect_prog #(.PAT_W(2), .CNT_W(2)) u_dut_c (
    .clk(clk), .reset(reset), .load(load_c), .pattern_in(pattern_c), .overlap(overlap),
    .din_valid(din_valid), .din(din), .armed(armed_c), .match(match_c), .match_count(count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pat_w_of(input int w);
    return (w == 0) ? 4 : (w == 1) ? 3 : 2;
  endfunction

  function automatic int get_armed(input int w);
    return (w == 0) ? int'(armed_a) : (w == 1) ? int'(armed_b) : int'(armed_c);
  endfunction

  function automatic int get_match(input int w);
    return (w == 0) ? int'(match_a) : (w == 1) ? int'(match_b) : int'(match_c);
  endfunction

  function automatic int get_count(input int w);
    return (w == 0) ? int'(count_a) : (w == 1) ? int'(count_b) : int'(count_c);
  endfunction

  task automatic wait_armed(input int w, input string tag);
    int n;
    n = 0;
    while (get_armed(w) == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_build_cycles"}, n, pat_w_of(w) + 1);
  endtask

  // Called on a negedge; returns on the negedge once the detector is armed.
  task automatic load_inst(input int w, input logic [15:0] pat, input logic ov, input string tag);
    logic [15:0] p;
    p         = pat;
    overlap   = ov;
    din_valid = 1'b0;
    case (w)
      0: begin pattern_a = p[3:0]; load_a = 1'b1; end
      1: begin pattern_b = p[2:0]; load_b = 1'b1; end
      default: begin pattern_c = p[1:0]; load_c = 1'b1; end
    endcase
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
    load_c = 1'b0;
    chk({tag, "_armed_after_load"}, get_armed(w), 0);
    chk({tag, "_count_cleared"}, get_count(w), 0);
    wait_armed(w, tag);
  endtask

  task automatic send_bit(input int w, input logic b, input logic exp_m, input string tag);
    din       = b;
    din_valid = 1'b1;
    #1;
    chk(tag, get_match(w), int'(exp_m));
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // bits and exp are MSB-first: stream position j (1-based) is bit [n-j].
  task automatic run_stream(input int w, input logic [15:0] bits, input logic [15:0] exp,
                            input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      send_bit(w, bits[n-1-i], exp[n-1-i], $sformatf("%s_bit%0d", tag, i + 1));
    end
  endtask

  initial begin
    reset     = 1'b0;
    overlap   = 1'b0;
    din_valid = 1'b1;
    din       = 1'b1;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    pattern_a = '0;
    pattern_b = '0;
    pattern_c = '0;

    #12;
    chk("rst_armed_a", armed_a, 0);
    chk("rst_match_a", match_a, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_armed_c", armed_c, 0);
    chk("rst_count_c", count_c, 0);
    @(negedge clk);
    din_valid = 1'b0;
    reset     = 1'b1;

    run_stream(0, 16'b1010, 16'b0000, 4, "idle_after_rst");
    chk("idle_armed", armed_a, 0);
    chk("idle_count", count_a, 0);

    load_inst(0, 16'b1010, 1'b1, "a_ovl");
    run_stream(0, 16'b1010101, 16'b0001010, 7, "a_ovl");
    chk("a_ovl_count", count_a, 2);

    for (int i = 0; i < 3; i++) begin
      din       = i[0];
      din_valid = 1'b0;
      #1;
      chk($sformatf("hold_nomatch%0d", i), match_a, 0);
      @(negedge clk);
    end
    send_bit(0, 1'b0, 1'b1, "hold_then_match");
    chk("hold_count", count_a, 3);

    load_inst(0, 16'b1010, 1'b0, "a_novl");
    run_stream(0, 16'b1010101, 16'b0001000, 7, "a_novl");
    chk("a_novl_count", count_a, 1);

    load_inst(0, 16'b0110, 1'b1, "a_reload");
    run_stream(0, 16'b0110, 16'b0001, 4, "a_reload");
    chk("a_reload_count", count_a, 1);

    load_inst(0, 16'b1010, 1'b1, "a_lm");
    run_stream(0, 16'b101, 16'b000, 3, "a_lm_pre");
    pattern_a = 4'b1010;
    overlap   = 1'b1;
    load_a    = 1'b1;
    din       = 1'b0;
    din_valid = 1'b1;
    #1;
    chk("lm_match_seen", match_a, 1);
    @(negedge clk);
    load_a    = 1'b0;
    din_valid = 1'b0;
    chk("lm_count_cleared", count_a, 0);
    wait_armed(0, "a_lm");
    run_stream(0, 16'b1010, 16'b0001, 4, "a_lm_post");
    chk("lm_post_count", count_a, 1);

    pattern_a = 4'b1010;
    load_a    = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    @(negedge clk);
    #2;
    reset     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b1;
    #1;
    chk("midrst_armed", armed_a, 0);
    chk("midrst_count", count_a, 0);
    chk("midrst_match", match_a, 0);
    @(negedge clk);
    din_valid = 1'b0;
    reset     = 1'b1;
    run_stream(0, 16'b1010, 16'b0000, 4, "postrst");
    chk("postrst_armed", armed_a, 0);
    chk("postrst_count", count_a, 0);
    load_inst(0, 16'b1010, 1'b1, "a_rearm");
    run_stream(0, 16'b1010, 16'b0001, 4, "a_rearm");
    chk("a_rearm_count", count_a, 1);

    load_inst(1, 16'b110, 1'b0, "b110");
    run_stream(1, 16'b1110, 16'b0001, 4, "b110");
    chk("b110_count", count_b, 1);
    load_inst(1, 16'b111, 1'b1, "b111");
    run_stream(1, 16'b11111, 16'b00111, 5, "b111");
    chk("b111_count", count_b, 3);

    load_inst(2, 16'b11, 1'b1, "c_sat");
    run_stream(2, 16'b1111, 16'b0111, 4, "c_sat_a");
    chk("c_sat_count3", count_c, 3);
    run_stream(2, 16'b11, 16'b11, 2, "c_sat_b");
    chk("c_sat_hold", count_c, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8, match counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  one-cycle strobe that captures pattern_in and overlap and starts a table build.
REQ-006 pattern_in  input  PAT_W  target sequence, MSB is the first bit received.
REQ-007 overlap  input  1  mode, 1 = overlapping detection, 0 = non-overlapping; sampled only on load.
REQ-008 din_valid  input  1  qualifies din in the current cycle.
REQ-009 din  input  1  serial data bit.
REQ-010 armed  output  1  high when the detector is in RUN and accepting data.
REQ-011 match  output  1  Mealy output, combinational from din, din_valid and the current state.
REQ-012 match_count  output  CNT_W  saturating count of matches since the last load or reset.

Function
REQ-013 Control FSM states: IDLE (no pattern), BUILD (transition table under construction), RUN (detecting).
REQ-014 IDLE -> BUILD on load; RUN -> BUILD on load; BUILD -> RUN after PAT_W+1 cycles; no other transitions.
REQ-015 On load, latch pattern_in and overlap, clear match_count, and set progress (matched-prefix length, 0..PAT_W-1) to 0.
REQ-016 A load during BUILD restarts the build with the new pattern.
REQ-017 BUILD computes one row k per cycle for k = 0..PAT_W: next-state pairs delta(k,0) and delta(k,1) via the KMP recurrence, where delta(k,b) = k+1 if pattern bit k equals b, else 0 if k = 0, else delta(fail(k),b).
REQ-018 Row PAT_W holds the border length B of the full pattern, the post-match state used in overlap mode.
REQ-019 In RUN, with din_valid high: match = 1 iff progress = PAT_W-1 and din equals the last pattern bit; match is 0 in all other cases and whenever armed = 0 or din_valid = 0.
REQ-020 On a match, next progress = B if overlap = 1, else 0; otherwise next progress = delta(progress, din).
REQ-021 With din_valid low, progress holds.
REQ-022 din is ignored in IDLE and BUILD.
REQ-023 match_count increments by 1 on each match cycle and saturates at 2^CNT_W-1 with no wrap.
REQ-024 A load in the same cycle as a match suppresses that count increment; the clear takes priority.
REQ-025 Match-to-count latency is 1 cycle; match itself has zero latency.

Reset
REQ-026 Asserting reset (reset = 0) forces IDLE, progress = 0, armed = 0, match_count = 0, and clears the latched pattern and table, at any time including mid-BUILD or mid-RUN.
REQ-027 match is 0 during reset.
REQ-028 After reset deassertion, the block stays in IDLE until load.

Structure
REQ-029 A shared package holds the FSM state enum (IDLE, BUILD, RUN), the PAT_W range limits, and the progress index width function clog2(PAT_W+1).
REQ-030 Table construction is one sub-module, seq_dfa_builder: inputs pattern and start; outputs the delta table, B, and done.
REQ-031 The top level holds the control FSM, progress register, match logic and counter.

Verification
REQ-032 PAT_W=4, pattern 1010, overlap=1, stream 1,0,1,0,1,0,1 -> match high on bits 4 and 6, match_count = 2.
REQ-033 Same pattern, overlap=0, same stream -> match on bit 4 only, match_count = 1.
REQ-034 Pattern 110, stream 1,1,1,0 -> single match on bit 4; pattern 111, overlap=1, stream of five 1s -> matches on bits 3, 4 and 5, count = 3.
REQ-035 CNT_W=2, overlap=1, pattern 11, stream of six 1s -> count saturates at 3 and stays at 3.
REQ-036 load mid-RUN while progress = 3 -> armed low for PAT_W+1 cycles, count = 0, no match on the old pattern afterwards.
REQ-037 reset asserted mid-BUILD, then a full pattern presented after deassertion -> armed = 0, no match, count = 0 until a new load completes.
